// File: rtl/filter_index_fetch_if.sv
// filter_index_fetch_if
//   Bus between the index fetcher, its compressed weight buffer and the
//   per-PE filter index decoder.
//   master : fetcher side (drives buffer reads and the decoder group stream)
//   slave  : buffer/decoder side (returns rd_data, drives stall)
//   Signals: rd_en/rd_addr/rd_data (buffer read port), index_vector,
//   weight_vector, lane_valid, out_valid (group stream), K_changing, next_a
//   (decoder control pulses), stall (downstream hold).
interface filter_index_fetch_if #(
  parameter int F      = 4,
  parameter int IDX_W  = 4,
  parameter int VAL_W  = 8,
  parameter int ADDR_W = 4
);
  logic                          rd_en;
  logic [ADDR_W-1:0]             rd_addr;
  logic [F*(IDX_W+VAL_W)-1:0]    rd_data;
  logic [F-1:0][IDX_W-1:0]       index_vector;
  logic [F-1:0][VAL_W-1:0]       weight_vector;
  logic [F-1:0]                  lane_valid;
  logic                          out_valid;
  logic                          K_changing;
  logic                          next_a;
  logic                          stall;

  modport master (
    output rd_en, rd_addr, index_vector, weight_vector, lane_valid,
           out_valid, K_changing, next_a,
    input  rd_data, stall
  );

  modport slave (
    input  rd_en, rd_addr, index_vector, weight_vector, lane_valid,
           out_valid, K_changing, next_a,
    output rd_data, stall
  );
endinterface

// File: rtl/filter_index_fetch.sv
// filter_index_fetch
//   Streams the compressed weight buffer of one K group to the filter index
//   decoder as F-lane groups, replaying the whole set once per activation
//   group. Pads the tail group, generates K_changing / next_a and absorbs
//   stall through a one-entry skid register.
//   Ports: clk, rst (async, active high), start/num_weights/num_acts
//   (command, sampled in IDLE), busy/done (status), bus (master modport:
//   buffer read port + decoder group stream + stall).
//   rd_en/rd_addr are launched from flops; the buffer presents rd_data for
//   that address while rd_en is high, one cycle after the fetch decision.
//   The rd_en flop therefore doubles as the valid bit of the read pipe.
module filter_index_fetch #(
  parameter int F      = 4,
  parameter int IDX_W  = 4,
  parameter int VAL_W  = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = ADDR_W + $clog2(F) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_weights,
  input  logic [15:0]      num_acts,
  output logic             busy,
  output logic             done,
  filter_index_fetch_if.master bus
);
  localparam int LW = IDX_W + VAL_W;
  localparam int DW = F * LW;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_nx;

  logic [CNT_W-1:0] ngrp, tail, g_cnt;
  logic [15:0]      nact, a_cnt;
  logic             rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic             tag_lip, tag_last;
  logic [DW-1:0]    out_data, skid_data, ret_data;
  logic [F-1:0]     out_mask, skid_mask, ret_mask;
  logic             out_v, out_lip, out_last;
  logic             skid_v, skid_lip, skid_last;
  logic             k_chg_q, done_q;

  logic             acc, issue, cmd_empty, drain_done, lip_nx, last_nx;
  logic [CNT_W-1:0] ngrp_in, tail_in, eff_ngrp, eff_g;
  logic [15:0]      eff_nact, eff_a;

  assign ngrp_in    = (num_weights + CNT_W'(F - 1)) / CNT_W'(F);
  assign tail_in    = num_weights % CNT_W'(F);
  assign cmd_empty  = (num_weights == '0) || (num_acts == '0);
  assign acc        = out_v && !bus.stall;
  // Either the final group leaves, or an empty command has nothing in flight.
  assign drain_done = (acc && out_last) || (!rd_en_q && !skid_v && !out_v);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    eff_ngrp = ngrp;
    eff_nact = nact;
    eff_g    = g_cnt;
    eff_a    = a_cnt;
    // The first read goes out on the start edge, using the command inputs.
    if (state == IDLE) begin
      eff_ngrp = ngrp_in;
      eff_nact = num_acts;
      eff_g    = '0;
      eff_a    = '0;
    end
    lip_nx  = (eff_g == eff_ngrp - CNT_W'(1));
    last_nx = lip_nx && (eff_a == eff_nact - 16'd1);
    case (state)
      IDLE: if (start) begin
        issue    = !cmd_empty;
        state_nx = (cmd_empty || last_nx) ? FLUSH : RUN;
      end
      RUN: begin
        issue = !skid_v && (!out_v || acc);
        if (issue && last_nx) state_nx = FLUSH;
      end
      FLUSH: if (drain_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      tag_lip   <= 1'b0;
      tag_last  <= 1'b0;
      g_cnt     <= '0;
      a_cnt     <= '0;
      ngrp      <= '0;
      tail      <= '0;
      nact      <= '0;
      k_chg_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      k_chg_q <= (state == IDLE) && start;
      done_q  <= (state == FLUSH) && drain_done;
      rd_en_q <= issue;
      if ((state == IDLE) && start) begin
        ngrp <= ngrp_in;
        tail <= tail_in;
        nact <= num_acts;
        g_cnt <= '0;
        a_cnt <= '0;
      end
      if (issue) begin
        rd_addr_q <= eff_g[ADDR_W-1:0];
        tag_lip   <= lip_nx;
        tag_last  <= last_nx;
        if (lip_nx) begin
          g_cnt <= '0;
          a_cnt <= eff_a + 16'd1;
        end else begin
          g_cnt <= eff_g + CNT_W'(1);
          a_cnt <= eff_a;
        end
      end
    end
  end

  // Tail padding: lanes at or beyond tail in the last group of a pass.
  always_comb begin
    ret_data = '0;
    ret_mask = '0;
    for (int i = 0; i < F; i++) begin
      if (!(tag_lip && (tail != '0) && (CNT_W'(i) >= tail))) begin
        ret_mask[i]          = 1'b1;
        ret_data[i*LW +: LW] = bus.rd_data[i*LW +: LW];
      end
    end
  end

  // Skid drains into the output register before newer returning data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v <= 1'b0; out_data <= '0; out_mask <= '0; out_lip <= 1'b0; out_last <= 1'b0;
      skid_v <= 1'b0; skid_data <= '0; skid_mask <= '0; skid_lip <= 1'b0; skid_last <= 1'b0;
    end else if (!out_v || acc) begin
      if (skid_v) begin
        out_v <= 1'b1; out_data <= skid_data; out_mask <= skid_mask;
        out_lip <= skid_lip; out_last <= skid_last;
        skid_v <= rd_en_q;
        skid_data <= rd_en_q ? ret_data : '0;
        skid_mask <= rd_en_q ? ret_mask : '0;
        skid_lip  <= rd_en_q && tag_lip;
        skid_last <= rd_en_q && tag_last;
      end else if (rd_en_q) begin
        out_v <= 1'b1; out_data <= ret_data; out_mask <= ret_mask;
        out_lip <= tag_lip; out_last <= tag_last;
      end else begin
        out_v <= 1'b0; out_data <= '0; out_mask <= '0; out_lip <= 1'b0; out_last <= 1'b0;
      end
    end else if (rd_en_q) begin
      skid_v <= 1'b1; skid_data <= ret_data; skid_mask <= ret_mask;
      skid_lip <= tag_lip; skid_last <= tag_last;
    end
  end

  always_comb begin
    bus.index_vector  = '0;
    bus.weight_vector = '0;
    for (int i = 0; i < F; i++) begin
      bus.index_vector[i]  = out_data[i*LW + VAL_W +: IDX_W];
      bus.weight_vector[i] = out_data[i*LW +: VAL_W];
    end
  end

  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.lane_valid = out_mask;
  assign bus.out_valid  = out_v;
  assign bus.K_changing = k_chg_q;
  assign bus.next_a     = acc && out_lip;
  assign busy           = (state != IDLE);
  assign done           = done_q;
endmodule

// File: tb/tb_filter_index_fetch.sv
module tb_filter_index_fetch;
  localparam int F = 4, IDX_W = 4, VAL_W = 8, ADDR_W = 4;
  localparam int CNT_W = ADDR_W + $clog2(F) + 1;
  localparam int LW = IDX_W + VAL_W;
  localparam int DW = F * LW;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [CNT_W-1:0] num_weights = '0;
  logic [15:0] num_acts = '0;
  logic busy, done;

  filter_index_fetch_if #(.F(F), .IDX_W(IDX_W), .VAL_W(VAL_W), .ADDR_W(ADDR_W)) bus ();

  filter_index_fetch #(.F(F), .IDX_W(IDX_W), .VAL_W(VAL_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_weights(num_weights),
    .num_acts(num_acts), .busy(busy), .done(done), .bus(bus.master)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<ADDR_W)-1];
  assign bus.rd_data = mem[bus.rd_addr];

  typedef struct {
    logic [F-1:0][IDX_W-1:0] idx;
    logic [F-1:0][VAL_W-1:0] wgt;
    logic [F-1:0]            lv;
    logic                    na;
  } exp_t;

  exp_t expq[$];
  int   expa[$];
  int total = 0, bad = 0;
  int grp_cnt = 0, done_cnt = 0, rd_cnt = 0;
  int d0_snap, g0_snap, r0_snap;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: group g of a pass holds weights g*F .. g*F+F-1; a lane is
  // live only if its weight position is below num_weights.
  task automatic push_model(int nw, int na);
    int ngrp;
    logic [DW-1:0] word;
    exp_t e;
    ngrp = (nw + F - 1) / F;
    for (int a = 0; a < na; a++) begin
      for (int g = 0; g < ngrp; g++) begin
        word = mem[g];
        for (int i = 0; i < F; i++) begin
          if (g * F + i < nw) begin
            e.idx[i] = word[i*LW + VAL_W +: IDX_W];
            e.wgt[i] = word[i*LW +: VAL_W];
            e.lv[i]  = 1'b1;
          end else begin
            e.idx[i] = '0;
            e.wgt[i] = '0;
            e.lv[i]  = 1'b0;
          end
        end
        e.na = (g == ngrp - 1);
        expq.push_back(e);
        expa.push_back(g);
      end
    end
  endtask

  // Monitor / scoreboard
  logic hold_prev = 1'b0;
  logic [F-1:0][IDX_W-1:0] h_idx;
  logic [F-1:0][VAL_W-1:0] h_wgt;
  logic [F-1:0] h_lv;
  exp_t me;
  int   ma;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 64'(bus.out_valid), 64'(1));
        chk("hold_index", 64'(bus.index_vector), 64'(h_idx));
        chk("hold_weight", 64'(bus.weight_vector), 64'(h_wgt));
        chk("hold_lane_valid", 64'(bus.lane_valid), 64'(h_lv));
      end
      if (bus.out_valid && bus.stall) chk("next_a_while_stalled", 64'(bus.next_a), 64'(0));
      if (bus.out_valid && !bus.stall) begin
        grp_cnt++;
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_group actual=valid required=no_group");
        end else begin
          me = expq.pop_front();
          chk("index_vector", 64'(bus.index_vector), 64'(me.idx));
          chk("weight_vector", 64'(bus.weight_vector), 64'(me.wgt));
          chk("lane_valid", 64'(bus.lane_valid), 64'(me.lv));
          chk("next_a", 64'(bus.next_a), 64'(me.na));
        end
      end
      if (bus.rd_en) begin
        rd_cnt++;
        if (expa.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_read actual=addr_%0d required=no_read", bus.rd_addr);
        end else begin
          ma = expa.pop_front();
          chk("rd_addr", 64'(bus.rd_addr), 64'(ma));
        end
      end
      if (done) done_cnt++;
      hold_prev = bus.out_valid && bus.stall;
      h_idx = bus.index_vector;
      h_wgt = bus.weight_vector;
      h_lv  = bus.lane_valid;
    end
  end

  task automatic fill_mem();
    for (int w = 0; w < (1 << ADDR_W); w++) mem[w] = DW'({$urandom(), $urandom()});
  endtask

  task automatic issue_cmd(int nw, int na);
    push_model(nw, na);
    d0_snap = done_cnt; g0_snap = grp_cnt; r0_snap = rd_cnt;
    @(posedge clk); #1;
    start = 1'b1; num_weights = CNT_W'(nw); num_acts = 16'(na);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(int exp_groups, bit rnd);
    int c = 0;
    while (done_cnt == d0_snap && c < 3000) begin
      @(posedge clk); #1;
      bus.stall = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      c++;
    end
    bus.stall = 1'b0;
    chk("done_count", 64'(done_cnt - d0_snap), 64'(1));
    chk("group_count", 64'(grp_cnt - g0_snap), 64'(exp_groups));
    chk("expected_queue_drained", 64'(expq.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, na, c;
    bus.stall = 1'b0;
    fill_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset_rd_en", 64'(bus.rd_en), 64'(0));
    chk("reset_busy_done", 64'({busy, done}), 64'(0));
    rst = 1'b0;

    // Basic latency: 8 weights, one pass
    issue_cmd(8, 1);
    @(negedge clk);
    chk("c1_K_changing", 64'(bus.K_changing), 64'(1));
    chk("c1_busy", 64'(busy), 64'(1));
    chk("c1_rd_en", 64'(bus.rd_en), 64'(1));
    chk("c1_out_valid", 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    chk("c2_out_valid", 64'(bus.out_valid), 64'(1));
    chk("c2_K_changing", 64'(bus.K_changing), 64'(0));
    @(negedge clk);
    chk("c3_out_valid", 64'(bus.out_valid), 64'(1));
    chk("c3_next_a", 64'(bus.next_a), 64'(1));
    @(negedge clk);
    chk("c4_done", 64'(done), 64'(1));
    chk("c4_busy", 64'(busy), 64'(0));
    wait_done(2, 1'b0);

    // Tail padding over three passes
    issue_cmd(6, 3);
    wait_done(6, 1'b0);

    // Stall on the first returned group
    issue_cmd(16, 1);
    @(posedge clk); #1; bus.stall = 1'b1;
    @(negedge clk);
    chk("stall_c2_out_valid", 64'(bus.out_valid), 64'(1));
    @(negedge clk);
    chk("stall_c3_rd_en", 64'(bus.rd_en), 64'(0));
    @(negedge clk);
    chk("stall_c4_rd_en", 64'(bus.rd_en), 64'(0));
    @(posedge clk); #1; bus.stall = 1'b0;
    wait_done(4, 1'b0);

    // Empty commands
    issue_cmd(0, 1);
    @(negedge clk);
    chk("zero_w_busy", 64'(busy), 64'(1));
    chk("zero_w_done_early", 64'(done), 64'(0));
    @(negedge clk);
    chk("zero_w_done", 64'(done), 64'(1));
    repeat (3) @(negedge clk);
    chk("zero_w_reads", 64'(rd_cnt - r0_snap), 64'(0));
    chk("zero_w_groups", 64'(grp_cnt - g0_snap), 64'(0));
    issue_cmd(8, 0);
    @(negedge clk);
    @(negedge clk);
    chk("zero_a_done", 64'(done), 64'(1));
    repeat (3) @(negedge clk);
    chk("zero_a_reads", 64'(rd_cnt - r0_snap), 64'(0));
    chk("zero_a_groups", 64'(grp_cnt - g0_snap), 64'(0));

    // Reset mid-pass
    issue_cmd(32, 2);
    c = 0;
    while (!bus.out_valid && c < 20) begin @(negedge clk); c++; end
    @(negedge clk);
    chk("pre_reset_out_valid", 64'(bus.out_valid), 64'(1));
    #2; rst = 1'b1; #1;
    chk("rst_out_valid_lanes", 64'({bus.out_valid, bus.lane_valid}), 64'(0));
    chk("rst_vectors", 64'({bus.index_vector, bus.weight_vector}), 64'(0));
    chk("rst_rd", 64'({bus.rd_en, bus.rd_addr}), 64'(0));
    chk("rst_ctrl", 64'({bus.K_changing, bus.next_a, busy, done}), 64'(0));
    expq.delete(); expa.delete();
    @(posedge clk); #1; rst = 1'b0;
    chk("rst_no_done", 64'(done_cnt - d0_snap), 64'(0));
    issue_cmd(12, 2);
    wait_done(6, 1'b0);

    // Start while busy is ignored
    issue_cmd(20, 2);
    repeat (3) @(posedge clk);
    #1; start = 1'b1; num_weights = CNT_W'(4); num_acts = 16'd1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(10, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("busy_start_done_count", 64'(done_cnt - d0_snap), 64'(1));
    chk("busy_start_idle", 64'(busy), 64'(0));

    // Random commands with random stall
    for (int k = 0; k < 10; k++) begin
      fill_mem();
      nw = $urandom_range(1, F << ADDR_W);
      na = $urandom_range(1, 3);
      issue_cmd(nw, na);
      wait_done(((nw + F - 1) / F) * na, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/filter_index_fetch.md
# filter_index_fetch

Upstream feeder for the per-PE filter index decoder. It streams the compressed weight buffer of the current K group to the decoder as F-lane groups of run-length indices and weight values. The full compressed filter set is replayed once per activation group. The block generates the decoder's `K_changing` and `next_a` control pulses, pads the tail group, and absorbs back-pressure from the PE `stall` through a one-entry skid register.

## Interface
Parameters:
- `F`, `` `F ``: lanes per group (decoder width).
- `IDX_W`, `` $clog2(`max_index) ``: run-length index width.
- `VAL_W`, 8: weight value width.
- `ADDR_W`, `` $clog2(`max_compressed_weight_num) ``: weight buffer word address width (one word = F entries).
- `CNT_W`, `ADDR_W+$clog2(F)+1`: weight count width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin one K group; ignored unless idle.
- `num_weights` in CNT_W: nonzero weights in the K group; sampled on start.
- `num_acts` in 16: activation groups to replay over; sampled on start.
- `stall` in 1: downstream hold; output must not change while high.
- `rd_en` out 1: buffer read strobe.
- `rd_addr` out ADDR_W: word address.
- `rd_data` in F*(IDX_W+VAL_W): returned word, 1-cycle latency. Lane i occupies bits [i*(IDX_W+VAL_W) +: IDX_W+VAL_W], with the index in the upper bits.
- `index_vector` out F×IDX_W: indices to the decoder.
- `weight_vector` out F×VAL_W: weight values.
- `lane_valid` out F: per-lane valid (tail mask).
- `out_valid` out 1: group presented.
- `K_changing` out 1: one-cycle pulse that clears decoder state for a new K group.
- `next_a` out 1: one-cycle pulse on the last group of each activation pass.
- `busy` out 1: high from start acceptance until done.
- `done` out 1: one-cycle pulse after the final group is accepted.

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: if `start`, do the following, then go to RUN:
  - latch `ngrp = ceil(num_weights/F)`, `tail = num_weights mod F` (0 means full), and `nact = num_acts`;
  - clear `a_cnt` and `g_cnt`;
  - pulse `K_changing` the next cycle.
- `start` in IDLE with `num_weights==0` or `num_acts==0`: go directly to FLUSH. No reads, no groups, no `next_a`.
- RUN:
  - A read is issued (`rd_en=1`, `rd_addr=g_cnt`) when the skid register is empty and either the output register is empty or will be accepted this cycle.
  - After each issued read, `g_cnt` increments. When `g_cnt == ngrp-1`, it wraps to 0 and `a_cnt` increments.
  - After the read with `a_cnt==nact-1` and `g_cnt==ngrp-1` is issued, go to FLUSH.
  - Each read carries a tag {`last_in_pass`, `last_overall`} through the one-cycle pipe.
- Returned data goes to the output register if it is empty or being accepted; otherwise it goes to the skid register. Skid contents move to the output register before any new data.
- Tail group (`last_in_pass` with `tail!=0`): lanes ≥ `tail` are forced to `lane_valid=0`, `index=0`, `value=0`. All other groups have `lane_valid` all ones.
- Output accepted = `out_valid & !stall`.
- `next_a` = accepted & `last_in_pass`. It is combinational from registered state and tag, and is never asserted while `stall` is high.
- FLUSH: wait until the pipe, the skid register and the output register are all empty. Then pulse `done` and return to IDLE.
- Counters compare at full width; `num_weights` up to `F*2^ADDR_W`.

## Timing
- Reset values:
  - `out_valid`, `lane_valid`, `index_vector`, `weight_vector`, `rd_en`, `rd_addr`, `K_changing`, `next_a`, `busy`, `done` are all 0.
  - State is IDLE and the skid register is empty.
- Start latency:
  - `start` sampled at edge t0 gives `K_changing=1`, `busy=1` and first `rd_en=1` in cycle t0+1.
  - The first `out_valid` is in cycle t0+2, so `K_changing` always precedes the first group by exactly one cycle.
- Throughput without stall: one group per cycle. Total groups = `ngrp*nact`.
- A stall of any length loses and duplicates no group. Outputs are held bit-stable during the stall.
- Rising stall in the same cycle as a returning read: the data goes to the skid register and `rd_en` drops the next cycle.
- `done` asserts one cycle after the final accepted group; `busy` falls with `done`.
- `start` while busy is ignored.
- `rst` mid-operation clears everything immediately, with no `done` pulse.

## Test plan
- F=4, `num_weights=8`, `num_acts=1`, no stall -> `K_changing` at t0+1; groups at word 0 and 1 in cycles t0+2, t0+3; `next_a` with the second group; `done` at t0+4.
- `num_weights=6`, `num_acts=3` -> 6 groups with address order 0,1,0,1,0,1; second group each pass has `lane_valid=4'b0011` and lanes 2–3 zeroed; `next_a` on groups 2, 4 and 6 only.
- `num_weights=16`, stall held 3 cycles starting on the cycle of the first returned group -> output register and skid register fill, `rd_en` low during the stall, all 4 words delivered once in order, `next_a` not asserted while stalled.
- `num_weights=0` and, separately, `num_acts=0` -> no `rd_en`, no `out_valid`, no `next_a`; `done` pulses 2 cycles after start.
- `rst` asserted mid-pass with `out_valid=1` -> all outputs 0 asynchronously; a subsequent `start` runs a full transfer correctly from address 0.
- `start` asserted while busy -> ignored; group count and `done` match the first command only.
